key_event_classifier: RTL and testbench
=======================================

// Module: key_event_classifier
// PURPOSE
//  Sits between key_debounce and beep_control; consumes debounced key_flag/key_value.
//  Classifies gestures as short press, double click or long press.
//  Emits one-cycle evt_flag with evt_code, so beep_control can play distinct patterns.
// PARAMETERS
//  CLK_FREQ    50_000_000  sys_clk frequency in Hz; ms tick period = CLK_FREQ/1000 cycles
//  LONG_MS     1000        hold time (ms) that makes a press "long"
//  GAP_MS      250         max release-to-press gap (ms) for a double click
//  REPEAT_MS   200         auto-repeat period (ms); used only with KEY_REPEAT_EN
// PORTS
//  sys_clk     in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  key_flag    in   1  1-cycle pulse: debounced key level changed
//  key_value   in   1  debounced level, valid when key_flag=1 (0=pressed, 1=released)
//  evt_flag    out  1  1-cycle pulse: gesture classified
//  evt_code    out  2  1=short, 2=double, 3=long/repeat; 0 only while evt_flag=0
//  busy        out  1  high in any state other than IDLE
// BEHAVIOUR
//  - Clock and reset: one clock (sys_clk); reset asynchronous, active-high.
//  - Reset: evt_flag=0, evt_code=0, busy=0, state=IDLE, timers=0.
//    Asserting rst mid-gesture aborts it with no event.
//  - Press edge = key_flag & ~key_value; release edge = key_flag & key_value.
//  - Timers count ms ticks from the tick sub-module and saturate at their threshold.
//    Each timer clears on every state entry; resolution is +0/-1 ms.
//  - States:
//    IDLE:   press -> PRESS1. Release ignored (e.g. key held through reset).
//    PRESS1: release before LONG_MS -> GAP.
//            Timer reaches LONG_MS while held -> emit long (3), go HOLD.
//    GAP:    press before GAP_MS -> PRESS2.
//            Timer reaches GAP_MS -> emit short (1), go IDLE.
//    PRESS2: release -> emit double (2), go IDLE.
//            Timer reaches LONG_MS while held -> emit long (3), go HOLD; first click discarded.
//    HOLD:   release -> IDLE with no event. Press edges here are ignored.
//  - Outputs are registered: evt_flag is high exactly one cycle, the cycle after the
//    deciding edge or timer hit; evt_code is valid in that same cycle, else 0.
//  - Any state change in the same cycle as a timer hit takes priority over the timer;
//    no event is emitted from the superseded branch.
//  - busy = (state != IDLE), registered with the state.
// CONFIGURATION
//  - KEY_REPEAT_EN defined: in HOLD, emit code 3 every REPEAT_MS while the key stays held.
//    The first repeat comes REPEAT_MS after the long event.
//  - KEY_REPEAT_EN undefined: HOLD emits nothing; the repeat timer and REPEAT_MS are unused.
// STRUCTURE
//  - Shared include key_evt_defs.vh holds:
//    - event code localparams EVT_SHORT=2'd1, EVT_DOUBLE=2'd2, EVT_LONG=2'd3;
//    - state encodings (one-hot, 5 bits);
//    - the ms-tick divisor expression, so beep_control can reuse the codes.
//  - One sub-module: ms_tick_gen (CLK_FREQ param) -> 1-cycle tick every CLK_FREQ/1000 cycles.
//  - Timer width: $clog2(max(LONG_MS, GAP_MS, REPEAT_MS) + 1).
// TESTING (CLK_FREQ=10_000 -> 10 cycles/ms; LONG_MS=20, GAP_MS=5, REPEAT_MS=4)
//  1. Press, release after 3 ms, no further press -> one evt_flag, code 1,
//     about 5 ms after the release; busy low after it.
//  2. Press 2 ms, release, press after 2 ms, release after 2 ms -> one code-2 event
//     the cycle after the second release; no code 1.
//  3. Hold 30 ms -> one code-3 event at about 20 ms; release gives no event.
//     With KEY_REPEAT_EN: further code-3 pulses at about 24 ms and 28 ms.
//  4. Key held through rst deassertion, then released -> no event, busy stays 0.
//  5. Assert rst during GAP 2 ms after a release -> evt_flag never pulses, busy=0
//     immediately (asynchronous); next clean click yields code 1.
//  6. Press edge on the same cycle as the GAP timer expiry -> goes to PRESS2, no short event;
//     release then yields code 2.

Source files
------------

// File: rtl/key_event_classifier_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the key gesture classifier: event codes, one-hot state
// encodings and helpers for the ms-tick divisor and timer width.
package key_event_classifier_pkg;

  typedef logic [1:0] evt_code_t;

  localparam evt_code_t EVT_NONE   = 2'd0;
  localparam evt_code_t EVT_SHORT  = 2'd1;
  localparam evt_code_t EVT_DOUBLE = 2'd2;
  localparam evt_code_t EVT_LONG   = 2'd3;

  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_PRESS1 = 5'b00010;
  localparam logic [4:0] ST_GAP    = 5'b00100;
  localparam logic [4:0] ST_PRESS2 = 5'b01000;
  localparam logic [4:0] ST_HOLD   = 5'b10000;

  // Clock cycles per millisecond tick.
  function automatic int unsigned ms_tick_div(input int unsigned clk_freq);
    return clk_freq / 1000;
  endfunction

  // Width that holds the largest of the three millisecond thresholds.
  function automatic int unsigned timer_width(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_event_classifier_if.sv
`timescale 1ns/1ps
// Key-in / event-out bundle between key_debounce, the classifier and beep_control.
// The master drives debounced key edges; the slave (classifier) returns events.
interface key_event_classifier_if;
  logic       key_flag;
  logic       key_value;
  logic       evt_flag;
  logic [1:0] evt_code;
  logic       busy;

  modport master (output key_flag, key_value, input evt_flag, evt_code, busy);
  modport slave  (input key_flag, key_value, output evt_flag, evt_code, busy);
endinterface

// File: rtl/key_event_classifier_ms_tick_gen.sv
`timescale 1ns/1ps
// ms_tick_gen: free-running divider producing a one-cycle tick every
// CLK_FREQ/1000 clock cycles.
module ms_tick_gen
  import key_event_classifier_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic sys_clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned DIV = ms_tick_div(CLK_FREQ);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/key_event_classifier.sv
`timescale 1ns/1ps
// key_event_classifier: turns debounced key edges into short / double / long events.
// Optional macro KEY_REPEAT_EN: keep emitting long (3) every REPEAT_MS while held.
module key_event_classifier
  import key_event_classifier_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned GAP_MS    = 250,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  key_event_classifier_if.slave kif
);
  localparam int unsigned   TW     = timer_width(LONG_MS, GAP_MS, REPEAT_MS);
  localparam logic [TW-1:0] LONG_T = TW'(LONG_MS);
  localparam logic [TW-1:0] GAP_T  = TW'(GAP_MS);
`ifdef KEY_REPEAT_EN
  localparam logic [TW-1:0] REPEAT_T = TW'(REPEAT_MS);
`endif

  logic          tick;
  logic [4:0]    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt, thr;
  logic          timer_hit, restart, emit;
  evt_code_t     code;
  logic          press_edge, release_edge;

  ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .sys_clk (sys_clk),
    .rst     (rst),
    .tick    (tick)
  );

  assign press_edge   = kif.key_flag & ~kif.key_value;
  assign release_edge = kif.key_flag &  kif.key_value;

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    thr = '0;
    case (state)
      ST_PRESS1, ST_PRESS2: thr = LONG_T;
      ST_GAP:               thr = GAP_T;
`ifdef KEY_REPEAT_EN
      ST_HOLD:              thr = REPEAT_T;
`endif
      default:              thr = '0;
    endcase
  end

  // A threshold of zero means the state has no timer (HOLD without repeat).
  assign timer_hit = tick & (thr != '0) & (timer == thr - TW'(1));

  // Key edges are tested before the timer so an edge always wins a tie.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    code      = EVT_NONE;
    restart   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press_edge) state_nxt = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (release_edge) begin
          state_nxt = ST_GAP;
        end else if (timer_hit) begin
          state_nxt = ST_HOLD;
          emit      = 1'b1;
          code      = EVT_LONG;
        end
      end
      ST_GAP: begin
        if (press_edge) begin
          state_nxt = ST_PRESS2;
        end else if (timer_hit) begin
          state_nxt = ST_IDLE;
          emit      = 1'b1;
          code      = EVT_SHORT;
        end
      end
      ST_PRESS2: begin
        if (release_edge) begin
          state_nxt = ST_IDLE;
          emit      = 1'b1;
          code      = EVT_DOUBLE;
        end else if (timer_hit) begin
          state_nxt = ST_HOLD;
          emit      = 1'b1;
          code      = EVT_LONG;
        end
      end
      ST_HOLD: begin
        if (release_edge) begin
          state_nxt = ST_IDLE;
`ifdef KEY_REPEAT_EN
        end else if (timer_hit) begin
          emit    = 1'b1;
          code    = EVT_LONG;
          restart = 1'b1;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Timer restarts on every state entry and saturates at the active threshold.
  always_comb begin
    timer_nxt = timer;
    if ((state_nxt != state) || restart) begin
      timer_nxt = '0;
    end else if (tick && (timer != thr)) begin
      timer_nxt = timer + TW'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      kif.evt_flag <= 1'b0;
      kif.evt_code <= EVT_NONE;
      kif.busy     <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      kif.evt_flag <= emit;
      kif.evt_code <= code;
      kif.busy     <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_key_event_classifier.sv
`timescale 1ns/1ps
// Self-checking bench for key_event_classifier: directed gestures plus random
// gestures classified by a millisecond-level model of the gesture rules.
module tb_key_event_classifier;
  localparam int unsigned CLK_FREQ  = 10_000;
  localparam int unsigned LONG_MS   = 20;
  localparam int unsigned GAP_MS    = 5;
  localparam int unsigned REPEAT_MS = 4;
  localparam int unsigned CPM       = CLK_FREQ / 1000;

  logic sys_clk = 1'b0;
  logic rst;

  key_event_classifier_if kif();

  key_event_classifier #(
    .CLK_FREQ  (CLK_FREQ),
    .LONG_MS   (LONG_MS),
    .GAP_MS    (GAP_MS),
    .REPEAT_MS (REPEAT_MS)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .kif     (kif)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc++;

  // Every observed event pulse, stamped with the posedge index that produced it.
  int unsigned ev_cyc[$];
  logic [1:0]  ev_code[$];
  int unsigned code_leak = 0;

  always @(negedge sys_clk) begin
    if (kif.evt_flag === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_code.push_back(kif.evt_code);
    end else if (kif.evt_code !== 2'd0) begin
      code_leak++;
    end
  end

  typedef struct {
    logic [1:0]  code;
    int unsigned lo;
    int unsigned hi;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic check_range(input string tag, input int unsigned got,
                             input int unsigned lo, input int unsigned hi);
    checks++;
    assert (got >= lo && got <= hi) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=[%0d..%0d]", tag, got, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge sys_clk);
      #1;
    end
  endtask

  // One-cycle debounced edge; returns the posedge index it was driven after.
  task automatic key_edge(input logic released, output int unsigned at);
    kif.key_flag  = 1'b1;
    kif.key_value = released;
    at = cyc;
    @(posedge sys_clk);
    #1;
    kif.key_flag = 1'b0;
  endtask

  // A timer of ms milliseconds started by an edge at 'start' fires with -1/+0 ms slack.
  task automatic expect_timer(input logic [1:0] code, input int unsigned start, input int unsigned ms);
    exp_q.push_back('{code, start + CPM * (ms - 1), start + CPM * ms + 3});
  endtask

  task automatic expect_at(input logic [1:0] code, input int unsigned c);
    exp_q.push_back('{code, c, c});
  endtask

  task automatic expect_long(input int unsigned press_at, input int unsigned held_ms);
    expect_timer(2'd3, press_at, LONG_MS);
`ifdef KEY_REPEAT_EN
    for (int k = 1; LONG_MS + k * REPEAT_MS < held_ms; k++)
      expect_timer(2'd3, press_at, LONG_MS + k * REPEAT_MS);
`else
    if (held_ms == 0) expect_timer(2'd0, press_at, 1);
`endif
  endtask

  task automatic compare_events(input string tag);
    check($sformatf("%s.count", tag), ev_cyc.size(), exp_q.size());
    for (int i = 0; i < ev_cyc.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s.code%0d", tag, i), ev_code[i], exp_q[i].code);
      check_range($sformatf("%s.time%0d", tag, i), ev_cyc[i], exp_q[i].lo, exp_q[i].hi);
    end
    ev_cyc.delete();
    ev_code.delete();
    exp_q.delete();
  endtask

  // Gesture: hold h1 ms; if short, gap g ms; if g is short, second hold h2 ms.
  task automatic do_gesture(input int unsigned h1, input int unsigned g,
                            input int unsigned h2, input string tag);
    int unsigned p1, r1, p2, r2;
    key_edge(1'b0, p1);
    check($sformatf("%s.busy_on", tag), kif.busy, 1);
    wait_cycles(h1 * CPM - 1);
    if (h1 >= LONG_MS) begin
      expect_long(p1, h1);
      key_edge(1'b1, r1);
    end else begin
      key_edge(1'b1, r1);
      if (g >= GAP_MS) begin
        expect_timer(2'd1, r1, GAP_MS);
      end else begin
        wait_cycles(g * CPM - 1);
        key_edge(1'b0, p2);
        wait_cycles(h2 * CPM - 1);
        if (h2 >= LONG_MS) begin
          expect_long(p2, h2);
          key_edge(1'b1, r2);
        end else begin
          key_edge(1'b1, r2);
          expect_at(2'd2, r2 + 1);
        end
      end
    end
    wait_cycles(12 * CPM);
    check($sformatf("%s.busy_off", tag), kif.busy, 0);
    compare_events(tag);
  endtask

  // Hold times stay at least 2 ms away from the long and repeat thresholds.
  function automatic int unsigned rand_hold();
    if ($urandom_range(0, 1) == 1) return $urandom_range(1, LONG_MS - 2);
    return LONG_MS + REPEAT_MS / 2 + REPEAT_MS * $urandom_range(0, 3);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t, r0, r1, d, h1, g, h2;

    rst           = 1'b1;
    kif.key_flag  = 1'b0;
    kif.key_value = 1'b1;
    wait_cycles(3);
    check("reset.evt_flag", kif.evt_flag, 0);
    check("reset.evt_code", kif.evt_code, 0);
    check("reset.busy", kif.busy, 0);
    rst = 1'b0;
    wait_cycles(3);

    // Short press, double click, long hold.
    do_gesture(3, 99, 0, "t1_short");
    do_gesture(2, 2, 2, "t2_double");
    do_gesture(30, 0, 0, "t3_long");

    // Key held through reset, then released: ignored.
    rst           = 1'b1;
    kif.key_value = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2 * CPM);
    check("t4.busy_held", kif.busy, 0);
    key_edge(1'b1, t);
    wait_cycles(8 * CPM);
    check("t4.busy_after", kif.busy, 0);
    compare_events("t4");

    // Reset asserted in the middle of GAP aborts the click.
    key_edge(1'b0, t);
    wait_cycles(2 * CPM - 1);
    key_edge(1'b1, t);
    wait_cycles(2 * CPM);
    #1;
    rst = 1'b1;
    #1;
    check("t5.busy_async", kif.busy, 0);
    check("t5.flag_async", kif.evt_flag, 0);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(10 * CPM);
    compare_events("t5_abort");
    do_gesture(3, 99, 0, "t5_clean");

    // Locate the GAP expiry cycle with a calibration click, then repeat the
    // click at the same tick phase with a press landing on that exact cycle.
    key_edge(1'b0, t);
    wait_cycles(3 * CPM - 1);
    key_edge(1'b1, r0);
    wait_cycles(10 * CPM);
    d = GAP_MS * CPM;
    check("t6_cal.count", ev_cyc.size(), 1);
    if (ev_cyc.size() > 0) begin
      check_range("t6_cal.time", ev_cyc[0], r0 + CPM * (GAP_MS - 1), r0 + CPM * GAP_MS + 3);
      if (ev_cyc[0] > r0 + 2) d = ev_cyc[0] - r0;
    end
    ev_cyc.delete();
    ev_code.delete();
    key_edge(1'b0, t);
    wait_cycles(3 * CPM - 1);
    while ((cyc - r0) % CPM != 0) wait_cycles(1);
    key_edge(1'b1, r1);
    wait_cycles(int'(d) - 2);
    key_edge(1'b0, t);
    wait_cycles(3 * CPM - 1);
    key_edge(1'b1, t);
    expect_at(2'd2, t + 1);
    wait_cycles(12 * CPM);
    check("t6.busy_off", kif.busy, 0);
    compare_events("t6_tie");

    // Random gestures classified by the model.
    for (int i = 0; i < 12; i++) begin
      h1 = rand_hold();
      g  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, GAP_MS - 2)
                                       : $urandom_range(GAP_MS + 2, GAP_MS + 6);
      h2 = rand_hold();
      do_gesture(h1, g, h2, $sformatf("rnd%0d", i));
    end

    check("code_while_idle", code_leak, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
